// File: rtl/bin2bcd_signed_pipe.sv
// Fully pipelined signed binary to sign-magnitude BCD converter. Each stage runs one double-dabble iteration.
// Optional build macro BIN2BCD_ZERO_INVALID_EN clears data stages that hold no valid sample.

module bin2bcd_signed_pipe_stage #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  in_sign,
  input  logic [4*DIGITS-1:0]   in_dig,
  input  logic                  in_bit,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_dig
);
  localparam int BW = 4*DIGITS;

  logic [BW-1:0] adj;

  always_comb begin
    adj = in_dig;
    for (int d = 0; d < DIGITS; d++)
      if (in_dig[4*d +: 4] >= 4'd5) adj[4*d +: 4] = in_dig[4*d +: 4] + 4'd3;
  end

  // The top bit of adj is shifted out; sizing DIGITS correctly keeps it zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      out_sign <= 1'b0;
      out_dig  <= '0;
    end else begin
      out_sign <= in_sign;
      out_dig  <= BW'({adj, in_bit});
    end
  end
endmodule

module bin2bcd_signed_pipe #(
  parameter int IN_W   = 11,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IN_W-1:0]       bin,
  input  logic                  bin_vld,
  output logic [4*DIGITS:0]     bcd,
  output logic                  bcd_vld
);
  localparam int BW = 4*DIGITS;

  logic [IN_W:0]            vld_pipe;
  logic                     sign0;
  logic [IN_W-1:0]          mag_pipe [IN_W];
  logic [IN_W:1]            sign_pipe;
  logic [IN_W:1][BW-1:0]    dig_pipe;
  logic [IN_W-1:0]          mag_in;

  // Negating -2^(IN_W-1) wraps to itself, which reads correctly as unsigned.
  assign mag_in = bin[IN_W-1] ? -bin : bin;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      sign0    <= 1'b0;
      for (int k = 0; k < IN_W; k++) mag_pipe[k] <= '0;
    end else begin
      vld_pipe <= {vld_pipe[IN_W-1:0], bin_vld};
`ifdef BIN2BCD_ZERO_INVALID_EN
      sign0       <= bin_vld & bin[IN_W-1];
      mag_pipe[0] <= bin_vld ? mag_in : '0;
      for (int k = 1; k < IN_W; k++)
        mag_pipe[k] <= vld_pipe[k-1] ? (mag_pipe[k-1] << 1) : '0;
`else
      sign0       <= bin[IN_W-1];
      mag_pipe[0] <= mag_in;
      for (int k = 1; k < IN_W; k++)
        mag_pipe[k] <= mag_pipe[k-1] << 1;
`endif
    end
  end

  for (genvar k = 1; k <= IN_W; k++) begin : g_stage
    logic [BW-1:0] dig_prev;
    logic          sign_prev;
    logic          clr;

    if (k == 1) begin : g_first
      assign dig_prev  = '0;
      assign sign_prev = sign0;
    end else begin : g_mid
      assign dig_prev  = dig_pipe[k-1];
      assign sign_prev = sign_pipe[k-1];
    end

`ifdef BIN2BCD_ZERO_INVALID_EN
    assign clr = rst | ~vld_pipe[k-1];
`else
    assign clr = rst;
`endif

    bin2bcd_signed_pipe_stage #(.DIGITS(DIGITS)) u_stage (
      .clk      (clk),
      .clr      (clr),
      .in_sign  (sign_prev),
      .in_dig   (dig_prev),
      .in_bit   (mag_pipe[k-1][IN_W-1]),
      .out_sign (sign_pipe[k]),
      .out_dig  (dig_pipe[k])
    );
  end

  assign bcd     = {sign_pipe[IN_W], dig_pipe[IN_W]};
  assign bcd_vld = vld_pipe[IN_W];
endmodule

// File: tb/tb_bin2bcd_signed_pipe.sv
// Self-checking bench for bin2bcd_signed_pipe: directed, sweep, random-gap and mid-stream reset scenarios.
module tb_bin2bcd_signed_pipe;
  localparam int IN_W = 11;
  localparam int DIGITS = 4;
  localparam int LAT = IN_W + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] bin;
  logic        bin_vld;
  logic [16:0] bcd;
  logic        bcd_vld;

  int errors = 0;
  int checks = 0;

  bin2bcd_signed_pipe #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .bin     (bin),
    .bin_vld (bin_vld),
    .bcd     (bcd),
    .bcd_vld (bcd_vld)
  );

  always #5 clk = ~clk;

  // Decimal digits of |value| by plain division, sign from the numeric value.
  function automatic logic [16:0] ref_bcd(input logic [10:0] b);
    int v, m;
    logic [16:0] r;
    v = int'($signed(b));
    m = (v < 0) ? -v : v;
    r = '0;
    r[16] = (v < 0);
    for (int d = 0; d < 4; d++) begin
      r[4*d +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1; bin_vld = 1'b1; bin = 11'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bcd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld cyc=%0d got=%b want=0", i, bcd_vld); end
      checks++;
      if (bcd !== 17'h0) begin errors++; $display("FAIL reset_bcd cyc=%0d got=%h want=0", i, bcd); end
      bin = 11'($urandom);
    end
    rst = 1'b0; bin_vld = 1'b0; bin = 11'd0;
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checks++;
      if (bcd_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld cyc=%0d got=%b want=0", i, bcd_vld); end
      if (i == 0) begin
        checks++;
        if (bcd !== 17'h0) begin errors++; $display("FAIL post_reset_bcd got=%h want=0", bcd); end
      end
    end
  endtask

  task automatic test_directed();
    logic [10:0] din  [6] = '{11'd1023, 11'h401, 11'h400, 11'd0, 11'h7FF, 11'd999};
    logic [16:0] dexp [6] = '{17'h01023, 17'h11023, 17'h11024, 17'h00000, 17'h10001, 17'h00999};
    logic ev;
    int tv;
    for (int t = 0; t < 6*4 + LAT + 2; t++) begin
      @(negedge clk);
      tv = t - LAT;
      ev = (tv >= 0) && (tv % 4 == 0) && (tv / 4 < 6);
      checks++;
      if (bcd_vld !== ev) begin errors++; $display("FAIL directed_vld t=%0d got=%b want=%b", t, bcd_vld, ev); end
      if (ev) begin
        checks++;
        if (bcd !== dexp[tv/4]) begin errors++; $display("FAIL directed_bcd in=%h got=%h want=%h", din[tv/4], bcd, dexp[tv/4]); end
      end
      if ((t % 4 == 0) && (t / 4 < 6)) begin bin_vld = 1'b1; bin = din[t/4]; end
      else begin bin_vld = 1'b0; bin = 11'($urandom); end
    end
  endtask

  task automatic test_sweep();
    logic [10:0] sb [$];
    logic ev;
    int nvld = 0;
    for (int t = 0; t < 2047 + LAT + 2; t++) begin
      @(negedge clk);
      ev = (t >= LAT) && (t - LAT < 2047);
      checks++;
      if (bcd_vld !== ev) begin errors++; $display("FAIL sweep_vld t=%0d got=%b want=%b", t, bcd_vld, ev); end
      if (ev) begin
        checks++;
        if (bcd !== ref_bcd(sb[t-LAT])) begin errors++; $display("FAIL sweep_bcd in=%h got=%h want=%h", sb[t-LAT], bcd, ref_bcd(sb[t-LAT])); end
      end
      if (bcd_vld === 1'b1) nvld++;
      if (t < 2047) begin bin_vld = 1'b1; bin = 11'(t - 1023); end
      else begin bin_vld = 1'b0; bin = 11'd0; end
      sb.push_back(bin);
    end
    checks++;
    if (nvld != 2047) begin errors++; $display("FAIL sweep_count got=%0d want=2047", nvld); end
  endtask

  task automatic test_random_gaps();
    logic [10:0] sb [$];
    logic        sv [$];
    logic ev;
    for (int t = 0; t < 400 + LAT + 2; t++) begin
      @(negedge clk);
      ev = (t >= LAT) ? sv[t-LAT] : 1'b0;
      checks++;
      if (bcd_vld !== ev) begin errors++; $display("FAIL gaps_vld t=%0d got=%b want=%b", t, bcd_vld, ev); end
      if (ev) begin
        checks++;
        if (bcd !== ref_bcd(sb[t-LAT])) begin errors++; $display("FAIL gaps_bcd in=%h got=%h want=%h", sb[t-LAT], bcd, ref_bcd(sb[t-LAT])); end
      end
      bin_vld = (t < 400) && ($urandom_range(0, 2) != 0);
      bin = bin_vld ? 11'($urandom) : 11'bx;
      sv.push_back(bin_vld);
      sb.push_back(bin);
    end
  endtask

  task automatic test_reset_midstream();
    logic [10:0] sb [$];
    logic        sv [$];
    logic ev, rst_last;
    rst_last = 1'b0;
    for (int t = 0; t < 60 + LAT + 2; t++) begin
      @(negedge clk);
      ev = (t >= LAT) ? sv[t-LAT] : 1'b0;
      checks++;
      if (bcd_vld !== ev) begin errors++; $display("FAIL rstmid_vld t=%0d got=%b want=%b", t, bcd_vld, ev); end
      if (ev) begin
        checks++;
        if (bcd !== ref_bcd(sb[t-LAT])) begin errors++; $display("FAIL rstmid_bcd in=%h got=%h want=%h", sb[t-LAT], bcd, ref_bcd(sb[t-LAT])); end
      end
      if (rst_last) begin
        checks++;
        if (bcd !== 17'h0) begin errors++; $display("FAIL rstmid_bcd_zero t=%0d got=%h want=0", t, bcd); end
      end
      rst = (t == 20) || (t == 21);
      bin_vld = (t < 60);
      bin = 11'($urandom);
      if (rst) begin
        for (int j = 0; j < sv.size(); j++) sv[j] = 1'b0;
        sv.push_back(1'b0);
      end else begin
        sv.push_back(bin_vld);
      end
      sb.push_back(bin);
      rst_last = rst;
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; bin_vld = 1'b0; bin = 11'd0;
    test_reset();
    test_directed();
    test_sweep();
    test_random_gaps();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
